gobang_line_scorer: RTL
=======================

# gobang_line_scorer

Parametrised line scorer for the gobang engine. It consumes one board line (row, column or diagonal) as a stream of 2-bit cells. It reports per colour:
- longest run,
- win flag (run ≥ WIN_LEN),
- count of open (WIN_LEN-1)-runs (empty cell on both sides).

Sits between the board-memory line walker and the move evaluator. It replaces the fixed 5-bit single-shot scorer with a configurable-length, handshaked scan.

## Interface
- LINE_LEN, 15, maximum cells per line; the scan is force-terminated at this count
- WIN_LEN, 5, run length that wins; also defines open run = WIN_LEN-1
- CNT_W, $clog2(LINE_LEN+1), width of run lengths and counts
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle pulse: clear results and begin a scan
- i_valid  in  1  i_cell/i_last valid this cycle
- i_cell  in  2  00 empty, 01 black, 10 white, 11 illegal
- i_last  in  1  final cell of the line (qualified by i_valid)
- o_ready  out  1  high in S_SCAN only; a cell is accepted when i_valid && o_ready
- o_done  out  1  one-cycle pulse in S_FINISH
- o_black_max, o_white_max  out  CNT_W  longest run per colour
- o_black_win, o_white_win  out  1  run ≥ WIN_LEN seen
- o_black_open, o_white_open  out  CNT_W  open (WIN_LEN-1)-run count, saturating
- o_err  out  1  illegal cell seen or line overran LINE_LEN

## Operation
- FSM states:
  - S_IDLE: o_ready=0.
  - S_SCAN: o_ready=1.
  - S_FINISH: o_done=1 for exactly one cycle, then S_IDLE.
- i_start in any state:
  - clears all result registers, run tracker and cell counter;
  - enters S_SCAN next cycle.
  - If i_start and i_valid arrive in the same cycle, i_start wins and the cell is dropped.
- Tracker registers:
  - cur_col: empty/black/white;
  - cur_run: CNT_W bits, saturating;
  - left_open: the cell before the current run was empty, not the line edge;
  - cell counter.
- Per accepted cell:
  - same non-empty colour as cur_col: cur_run+1;
  - otherwise: close the current run, with right side open iff the new cell is empty, then start a new run of 1 (or of 0 if the new cell is empty).
  - left_open is set when the previous cell was empty.
- Closing a run of colour C and length L:
  - C_max = max(C_max, L);
  - C_win |= (L ≥ WIN_LEN);
  - C_open += 1 (saturating) iff L == WIN_LEN-1 && left_open && right side open.
- End of line:
  - On i_last, or when the LINE_LEN-th cell is accepted, close the run with right side = edge (not open), then go to S_FINISH.
  - Reaching the LINE_LEN-th cell without i_last sets o_err.
- Illegal cell 11: treated as empty and sets o_err.
- Results hold from S_FINISH until the next i_start or reset; i_valid is ignored outside S_SCAN.

## Timing
- Reset values:
  - state S_IDLE;
  - o_ready=0, o_done=0;
  - all max/open counts 0, win flags 0, o_err 0.
- Reset mid-scan aborts immediately; no o_done pulse.
- Throughput: one cell per cycle, no bubbles.
- Latency: o_done and final results are valid in the cycle after the last cell is accepted. The outputs are registered; the final run close is written at the same clock edge that enters S_FINISH.
- A new i_start may be issued in the o_done cycle; the next scan begins the following cycle.

## Structure
- gobang_pkg holds:
  - cell_t enum (CELL_EMPTY, CELL_BLACK, CELL_WHITE, CELL_ILLEGAL);
  - scorer state enum (S_IDLE, S_SCAN, S_FINISH);
  - default LINE_LEN/WIN_LEN constants.
- Sub-module gobang_run_acc, instantiated once per colour:
  - inputs: close strobe, length, left_open, right_open;
  - holds max, win and open-count registers with the clear input.
- The top level holds the FSM, tracker and cell counter.

## Test plan
Defaults LINE_LEN=15, WIN_LEN=5; E/B/W = empty/black/white.
- E B B B B B, then E×9 (i_last on cell 15) → black_max=5, black_win=1, white_max=0, o_done one cycle after cell 15, o_err=0.
- E W W W W E, then E×9 → white_max=4, white_open=1, white_win=0. Same stream starting W W W W E (edge-bounded) → white_open=0.
- B×6, then E×9 → black_max=6, black_win=1, black_open=0.
- 16 valid cells, no i_last → o_ready drops after cell 15, o_err=1, o_done once, cell 16 ignored. A cell 11 anywhere in a line → o_err=1, scored as E.
- B B B, then i_start, then E×14 + E(last) → all results 0, exactly one o_done.
- i_rst_n low during cell 7 → next cycle all outputs 0, o_ready=0, no o_done until a fresh i_start.

Source files
------------

// File: rtl/gobang_pkg.sv
// gobang_pkg: shared types and default geometry for the gobang line scorer.
//   cell_t  - 2-bit board cell encoding as streamed by the line walker
//   state_t - scorer control states
//   LINE_LEN_DEF / WIN_LEN_DEF - default line length and winning run length
package gobang_pkg;

  localparam int LINE_LEN_DEF = 15;
  localparam int WIN_LEN_DEF  = 5;

  typedef enum logic [1:0] {
    CELL_EMPTY   = 2'b00,
    CELL_BLACK   = 2'b01,
    CELL_WHITE   = 2'b10,
    CELL_ILLEGAL = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/gobang_run_acc.sv
// gobang_run_acc: per-colour result accumulator. Each closed run updates the
// longest-run register, the win flag and the saturating open-run count.
//   i_clk, i_rst_n    - clock, async active-low reset
//   i_clear           - synchronous clear of all results (scan start)
//   i_close           - a run of this colour ends this cycle
//   i_len             - length of the closing run
//   i_left_open       - cell before the run was empty
//   i_right_open      - cell after the run is empty (not the line edge)
//   o_max/o_win/o_open - longest run, run >= WIN_LEN seen, open (WIN_LEN-1)-runs
module gobang_run_acc #(
  parameter int WIN_LEN = 5,
  parameter int CNT_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_close,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_left_open,
  input  logic             i_right_open,
  output logic [CNT_W-1:0] o_max,
  output logic             o_win,
  output logic [CNT_W-1:0] o_open
);

  logic [CNT_W-1:0] max_q, max_d, open_q, open_d;
  logic             win_q, win_d;

  always_comb begin
    max_d  = max_q;
    win_d  = win_q;
    open_d = open_q;
    if (i_clear) begin
      max_d  = '0;
      win_d  = 1'b0;
      open_d = '0;
    end else if (i_close) begin
      if (i_len > max_q) max_d = i_len;
      if (i_len >= CNT_W'(WIN_LEN)) win_d = 1'b1;
      if (i_len == CNT_W'(WIN_LEN - 1) && i_left_open && i_right_open && open_q != '1)
        open_d = open_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      max_q  <= '0;
      win_q  <= 1'b0;
      open_q <= '0;
    end else begin
      max_q  <= max_d;
      win_q  <= win_d;
      open_q <= open_d;
    end
  end

  assign o_max  = max_q;
  assign o_win  = win_q;
  assign o_open = open_q;

endmodule

// File: rtl/gobang_line_scorer.sv
// gobang_line_scorer: streams one board line (2-bit cells) and reports, per
// colour, longest run, win flag and count of open (WIN_LEN-1)-runs.
//   i_start  - clear results and begin a scan (wins over a same-cycle cell)
//   i_valid/i_cell/i_last - cell stream, accepted when i_valid && o_ready
//   o_ready  - high while scanning
//   o_done   - one-cycle pulse when results are final
//   o_{black,white}_{max,win,open} - per-colour results
//   o_err    - illegal cell seen or line ran to LINE_LEN without i_last
module gobang_line_scorer
  import gobang_pkg::*;
#(
  parameter int LINE_LEN = LINE_LEN_DEF,
  parameter int WIN_LEN  = WIN_LEN_DEF,
  parameter int CNT_W    = $clog2(LINE_LEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [1:0]       i_cell,
  input  logic             i_last,
  output logic             o_ready,
  output logic             o_done,
  output logic [CNT_W-1:0] o_black_max,
  output logic [CNT_W-1:0] o_white_max,
  output logic             o_black_win,
  output logic             o_white_win,
  output logic [CNT_W-1:0] o_black_open,
  output logic [CNT_W-1:0] o_white_open,
  output logic             o_err
);

  state_t           state_q, state_d;
  cell_t            cur_col_q, cur_col_d;
  logic [CNT_W-1:0] cur_run_q, cur_run_d, cnt_q, cnt_d;
  logic             left_open_q, left_open_d, err_q, err_d;

  cell_t            cell_in, cell_eff;
  logic             accept, at_limit, line_end, same, new_lo;
  logic [CNT_W-1:0] run_inc, new_run;

  assign cell_in  = cell_t'(i_cell);
  assign cell_eff = (cell_in == CELL_ILLEGAL) ? CELL_EMPTY : cell_in;
  assign accept   = i_valid && (state_q == S_SCAN) && !i_start;
  assign at_limit = (cnt_q == CNT_W'(LINE_LEN - 1));
  assign line_end = accept && (i_last || at_limit);
  assign same     = (cell_eff != CELL_EMPTY) && (cell_eff == cur_col_q);
  assign run_inc  = (cur_run_q == '1) ? cur_run_q : cur_run_q + 1'b1;
  assign new_run  = same ? run_inc : ((cell_eff == CELL_EMPTY) ? '0 : CNT_W'(1));
  // The first cell of a line has the edge on its left, hence the cnt_q check.
  assign new_lo   = same ? left_open_q : (cur_col_q == CELL_EMPTY && cnt_q != '0);

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (i_start) state_d = S_SCAN;
    else begin
      case (state_q)
        S_SCAN:   if (line_end) state_d = S_FINISH;
        S_FINISH: state_d = S_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    o_ready = (state_q == S_SCAN);
    o_done  = (state_q == S_FINISH);
  end

  // Run tracker and cell counter
  always_comb begin
    cur_col_d   = cur_col_q;
    cur_run_d   = cur_run_q;
    left_open_d = left_open_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    if (i_start) begin
      cur_col_d   = CELL_EMPTY;
      cur_run_d   = '0;
      left_open_d = 1'b0;
      cnt_d       = '0;
      err_d       = 1'b0;
    end else if (accept) begin
      cur_col_d   = cell_eff;
      cur_run_d   = new_run;
      left_open_d = new_lo;
      cnt_d       = cnt_q + 1'b1;
      err_d       = err_q | (cell_in == CELL_ILLEGAL) | (at_limit && !i_last);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_col_q   <= CELL_EMPTY;
      cur_run_q   <= '0;
      left_open_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      cur_col_q   <= cur_col_d;
      cur_run_q   <= cur_run_d;
      left_open_q <= left_open_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Per-colour close routing. In one cycle a colour sees at most one close:
  // either its current run ends because a different cell arrived, or the
  // line ends on a cell of this colour (edge-closed, right side not open).
  for (genvar c = 0; c < 2; c++) begin : g_col
    localparam cell_t COL = cell_t'(c + 1);
    logic             close, lo, ro, win;
    logic [CNT_W-1:0] len, max, open;

    always_comb begin
      close = 1'b0;
      len   = cur_run_q;
      lo    = left_open_q;
      ro    = (cell_eff == CELL_EMPTY);
      if (accept && !same && cur_col_q == COL) begin
        close = 1'b1;
      end else if (line_end && cell_eff == COL) begin
        close = 1'b1;
        len   = new_run;
        lo    = new_lo;
        ro    = 1'b0;
      end
    end

    gobang_run_acc #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) u_acc (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clear     (i_start),
      .i_close     (close),
      .i_len       (len),
      .i_left_open (lo),
      .i_right_open(ro),
      .o_max       (max),
      .o_win       (win),
      .o_open      (open)
    );
  end

  assign o_black_max  = g_col[0].max;
  assign o_black_win  = g_col[0].win;
  assign o_black_open = g_col[0].open;
  assign o_white_max  = g_col[1].max;
  assign o_white_win  = g_col[1].win;
  assign o_white_open = g_col[1].open;
  assign o_err        = err_q;

endmodule
